vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed-colour VGA generator.
- Produces VGA timing for any mode, with a configurable sync polarity.
- Generates one of four test patterns, selectable at run time: solid, colour bars, checkerboard, scrolling gradient.
- Mode and colour inputs are latched once per frame, so a frame never tears. Outputs are pipelined and registered, and sit directly on the VGA pins.

Parameters:
H_VIS_AREA_PXL, 800, visible pixels per line
H_FRONT_PORCH_PXL, 40, horizontal front porch
H_SYNC_PULSE_PXL, 128, horizontal sync width
H_BACK_PORCH_PXL, 88, horizontal back porch
H_NUM_BITS, 11, h counter width; must satisfy 2^H_NUM_BITS >= horizontal total
V_VIS_AREA_PXL, 600, visible lines
V_FRONT_PORCH_PXL, 1, vertical front porch
V_SYNC_PULSE_PXL, 4, vertical sync width
V_BACK_PORCH_PXL, 23, vertical back porch
V_NUM_BITS, 10, v counter width
H_SYNC_POL, 1, 1 = h_sync active high, 0 = active low
V_SYNC_POL, 1, same for v_sync
CHANNEL_BITS, 4, bits per colour channel
CHECKER_LOG2, 5, checker square size is 2^CHECKER_LOG2 pixels
FRAME_BITS, 8, frame counter width

Ports:
clk  in  1  pixel clock
aresetn  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 scroll
color  in  3*CHANNEL_BITS  {R,G,B} used by modes 0 and 2
red  out  CHANNEL_BITS  red channel
green  out  CHANNEL_BITS  green channel
blue  out  CHANNEL_BITS  blue channel
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
frame_start  out  1  one-cycle pulse, aligned with the output of pixel (0,0)

Behaviour:
- Reset state (aresetn low, asynchronous):
  - h_cnt, v_cnt, frame_cnt = 0; bar index = 0.
  - mode_q = 0; color_q = 0.
  - red, green, blue = 0; frame_start = 0.
  - h_sync = ~H_SYNC_POL; v_sync = ~V_SYNC_POL.
  - On release, counting starts on the first rising clk edge; pixel (0,0) reaches the outputs 2 cycles later.
- Counters:
  - H_TOTAL = sum of the four H parameters; h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
- Sync generation:
  - h_sync is active when H_VIS+HFP <= h_cnt < H_VIS+HFP+HSYNC.
  - v_sync is active by the same rule on v_cnt.
  - Active level = *_SYNC_POL.
- Visible region: visible = (h_cnt < H_VIS) && (v_cnt < V_VIS). Outside it, RGB = 0 in every mode.
- Frame latch: on the last pixel (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1):
  - mode_q <= mode; color_q <= color.
  - frame_cnt <= frame_cnt + 1, wrapping modulo 2^FRAME_BITS.
  - Mid-frame changes to mode or color have no effect until the next frame.
- Pipeline:
  - Stage 0: counters.
  - Stage 1: pattern computation, with visible, sync and frame_start delayed alongside.
  - Stage 2: output registers.
  - Latency from counter value to pins is exactly 2 cycles; RGB, syncs and frame_start stay aligned.
- Mode 0 (solid): RGB = color_q.
- Mode 1 (colour bars):
  - BAR_W = H_VIS/8. A bar sub-counter resets at h_cnt = 0; the bar index advances each BAR_W pixels and saturates at 7 (covers any remainder pixels).
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is either all-ones or 0.
- Mode 2 (checker):
  - sel = h_cnt[CHECKER_LOG2] XOR v_cnt[CHECKER_LOG2].
  - sel = 0 gives color_q; sel = 1 gives ~color_q, the bitwise inverse of each channel.
- Mode 3 (scroll), all arithmetic modulo 2^CHANNEL_BITS:
  - R = (h_cnt + frame_cnt) >> 2.
  - G = v_cnt >> 2.
  - B = frame_cnt.
  - Each result is truncated to its low CHANNEL_BITS.
- Reset asserted mid-frame: all state returns immediately to reset values, and the sync outputs go inactive.

Decomposition:
- Package vga_pkg holds:
  - timing total/threshold constant functions (H_TOTAL, V_TOTAL, sync start/end);
  - the MODE_SOLID/BARS/CHECKER/SCROLL encodings;
  - the 8-entry bar colour table as 3-bit RGB masks.
- Sub-module vga_timing generates h_cnt, v_cnt, visible, raw syncs and the last-pixel strobe. It is reusable by future GPU blocks.

Test Plan:
- Bench configuration: H 16/2/3/3 (total 24); V 8/1/2/1 (total 12); CHANNEL_BITS = 4; CHECKER_LOG2 = 2; polarity 1.
- Reset and sync: hold aresetn low for 5 cycles → RGB = 0, h_sync = 0, v_sync = 0. After release, h_sync is high for exactly 3 cycles per 24-cycle line, starting 18 cycles after the first visible pixel. v_sync is high for exactly 48 cycles per 288-cycle frame.
- Solid with mid-frame change: mode = 0, color = 12'hF80 → visible pixels are R = F, G = 8, B = 0. Change color to 12'h0F0 mid-frame → no change until the next frame_start, after which every visible pixel is 0F0. Blanking pixels are always 000.
- Bars: mode = 1 → pixels 0-1 are FFF, pixels 2-3 are FF0, …, pixels 14-15 are 000, on every visible line.
- Checker: mode = 2, color = 12'h123 → pixel (0,0) = 123, pixel (4,0) = EDC, pixel (4,4) = 123.
- Scroll, wrap and reset: mode = 3 for 20 frames → in frame 17, pixel (0,0) has B = 1 (17 mod 16) and R = (0+17)>>2 = 4. Drop aresetn mid-line → outputs are zero immediately. Set polarity 0 → syncs idle high.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA pattern generator and its timing core:
//   timing total/threshold helpers, pattern mode encodings and the colour
//   bar table (3-bit {R,G,B} masks, index 0 = leftmost bar).
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_e;

    // Packed so that BAR_RGB[0] is the first listed-last entry:
    // white, yellow, cyan, green, magenta, red, blue, black (left to right).
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic int calc_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // First counter value with sync asserted.
    function automatic int calc_sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    // First counter value after sync deasserts.
    function automatic int calc_sync_end(input int vis, input int fp, input int sync);
        return vis + fp + sync;
    endfunction

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Horizontal/vertical raster counters for an arbitrary VGA mode.
//   Ports:
//     clk_i, rst_ni      pixel clock, asynchronous active-low reset
//     h_cnt_o, v_cnt_o   current raster position
//     visible_o          position lies in the active picture
//     h_sync_act_o       horizontal sync active (polarity-free, 1 = active)
//     v_sync_act_o       vertical sync active (polarity-free, 1 = active)
//     line_end_o         last pixel of a line (h counter about to wrap)
//     frame_end_o        last pixel of a frame
//   All outputs are combinational functions of the counter registers.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS_AREA_PXL    = 800,
    parameter int H_FRONT_PORCH_PXL = 40,
    parameter int H_SYNC_PULSE_PXL  = 128,
    parameter int H_BACK_PORCH_PXL  = 88,
    parameter int H_NUM_BITS        = 11,
    parameter int V_VIS_AREA_PXL    = 600,
    parameter int V_FRONT_PORCH_PXL = 1,
    parameter int V_SYNC_PULSE_PXL  = 4,
    parameter int V_BACK_PORCH_PXL  = 23,
    parameter int V_NUM_BITS        = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [H_NUM_BITS-1:0] h_cnt_o,
    output logic [V_NUM_BITS-1:0] v_cnt_o,
    output logic                  visible_o,
    output logic                  h_sync_act_o,
    output logic                  v_sync_act_o,
    output logic                  line_end_o,
    output logic                  frame_end_o
);

    localparam int H_TOTAL = calc_total(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL,
                                        H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_TOTAL = calc_total(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL,
                                        V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);

    localparam logic [H_NUM_BITS-1:0] H_LAST     = H_NUM_BITS'(H_TOTAL - 1);
    localparam logic [H_NUM_BITS-1:0] H_VIS_END  = H_NUM_BITS'(H_VIS_AREA_PXL);
    localparam logic [H_NUM_BITS-1:0] H_SYNC_BEG =
        H_NUM_BITS'(calc_sync_start(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL));
    localparam logic [H_NUM_BITS-1:0] H_SYNC_END =
        H_NUM_BITS'(calc_sync_end(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL, H_SYNC_PULSE_PXL));

    localparam logic [V_NUM_BITS-1:0] V_LAST     = V_NUM_BITS'(V_TOTAL - 1);
    localparam logic [V_NUM_BITS-1:0] V_VIS_END  = V_NUM_BITS'(V_VIS_AREA_PXL);
    localparam logic [V_NUM_BITS-1:0] V_SYNC_BEG =
        V_NUM_BITS'(calc_sync_start(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL));
    localparam logic [V_NUM_BITS-1:0] V_SYNC_END =
        V_NUM_BITS'(calc_sync_end(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL, V_SYNC_PULSE_PXL));

    logic [H_NUM_BITS-1:0] h_cnt_q, h_cnt_d;
    logic [V_NUM_BITS-1:0] v_cnt_q, v_cnt_d;
    logic                  line_end;

    assign line_end = (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q + H_NUM_BITS'(1);
        v_cnt_d = v_cnt_q;
        if (line_end) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + V_NUM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign visible_o    = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    assign h_sync_act_o = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign v_sync_act_o = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    assign line_end_o   = line_end;
    assign frame_end_o  = line_end && (v_cnt_q == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA test-pattern generator for any timing mode and sync polarity.
//   Ports:
//     clk          pixel clock
//     aresetn      asynchronous active-low reset
//     mode         pattern: 0 solid, 1 colour bars, 2 checker, 3 scroll
//     color        {R,G,B} used by solid and checker patterns
//     red/green/blue  registered colour channels (0 outside the picture)
//     h_sync/v_sync   registered syncs, active level set by *_SYNC_POL
//     frame_start  one-cycle pulse, aligned with pixel (0,0) on the pins
//   Pipeline: counters -> pattern/side-band register -> output register,
//   so every output lags the raster counters by exactly two cycles.
//   mode/color are sampled only on the last pixel of a frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VIS_AREA_PXL    = 800,
    parameter int H_FRONT_PORCH_PXL = 40,
    parameter int H_SYNC_PULSE_PXL  = 128,
    parameter int H_BACK_PORCH_PXL  = 88,
    parameter int H_NUM_BITS        = 11,
    parameter int V_VIS_AREA_PXL    = 600,
    parameter int V_FRONT_PORCH_PXL = 1,
    parameter int V_SYNC_PULSE_PXL  = 4,
    parameter int V_BACK_PORCH_PXL  = 23,
    parameter int V_NUM_BITS        = 10,
    parameter int H_SYNC_POL        = 1,
    parameter int V_SYNC_POL        = 1,
    parameter int CHANNEL_BITS      = 4,
    parameter int CHECKER_LOG2      = 5,
    parameter int FRAME_BITS        = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [1:0]                mode,
    input  logic [3*CHANNEL_BITS-1:0] color,
    output logic [CHANNEL_BITS-1:0]   red,
    output logic [CHANNEL_BITS-1:0]   green,
    output logic [CHANNEL_BITS-1:0]   blue,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic                      frame_start
);

    localparam int CB      = CHANNEL_BITS;
    localparam int PIX_W   = 3 * CHANNEL_BITS;
    localparam int BAR_W   = H_VIS_AREA_PXL / 8;
    localparam logic [H_NUM_BITS-1:0] BAR_LAST = H_NUM_BITS'(BAR_W - 1);
    localparam logic H_ACT = (H_SYNC_POL != 0);
    localparam logic V_ACT = (V_SYNC_POL != 0);

    // ---------------- stage 0: raster counters ----------------
    logic [H_NUM_BITS-1:0] h_cnt;
    logic [V_NUM_BITS-1:0] v_cnt;
    logic visible, h_sync_act, v_sync_act, line_end, frame_end;

    vga_timing #(
        .H_VIS_AREA_PXL   (H_VIS_AREA_PXL),
        .H_FRONT_PORCH_PXL(H_FRONT_PORCH_PXL),
        .H_SYNC_PULSE_PXL (H_SYNC_PULSE_PXL),
        .H_BACK_PORCH_PXL (H_BACK_PORCH_PXL),
        .H_NUM_BITS       (H_NUM_BITS),
        .V_VIS_AREA_PXL   (V_VIS_AREA_PXL),
        .V_FRONT_PORCH_PXL(V_FRONT_PORCH_PXL),
        .V_SYNC_PULSE_PXL (V_SYNC_PULSE_PXL),
        .V_BACK_PORCH_PXL (V_BACK_PORCH_PXL),
        .V_NUM_BITS       (V_NUM_BITS)
    ) u_timing (
        .clk_i       (clk),
        .rst_ni      (aresetn),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .visible_o   (visible),
        .h_sync_act_o(h_sync_act),
        .v_sync_act_o(v_sync_act),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    // Bar index tracks h_cnt in stage 0, so a divider is not needed.
    // It saturates at the last bar, which absorbs any H_VIS % 8 remainder.
    logic [H_NUM_BITS-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]            bar_idx_q, bar_idx_d;

    always_comb begin
        bar_cnt_d = bar_cnt_q + H_NUM_BITS'(1);
        bar_idx_d = bar_idx_q;
        if (line_end) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end
    end

    // Per-frame settings; updated only on the last pixel so a frame never tears.
    mode_e                 mode_q, mode_d;
    logic [PIX_W-1:0]      color_q, color_d;
    logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        mode_d      = mode_q;
        color_d     = color_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_end) begin
            mode_d      = mode_e'(mode);
            color_d     = color;
            frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            mode_q      <= MODE_SOLID;
            color_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            color_q     <= color_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // ---------------- stage 1: pattern computation ----------------
    logic [2:0]       bar_rgb;
    logic             checker_sel;
    logic [CB-1:0]    scr_r, scr_g, scr_b;
    logic [PIX_W-1:0] pix_d;
    logic             first_pxl;

    assign bar_rgb     = bar_mask(bar_idx_q);
    assign checker_sel = h_cnt[CHECKER_LOG2] ^ v_cnt[CHECKER_LOG2];
    // Full-width sum before the shift, then keep the low channel bits.
    assign scr_r       = CB'((32'(h_cnt) + 32'(frame_cnt_q)) >> 2);
    assign scr_g       = CB'(32'(v_cnt) >> 2);
    assign scr_b       = CB'(32'(frame_cnt_q));
    assign first_pxl   = (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        pix_d = '0;
        case (mode_q)
            MODE_SOLID:   pix_d = color_q;
            MODE_BARS:    pix_d = {{CB{bar_rgb[2]}}, {CB{bar_rgb[1]}}, {CB{bar_rgb[0]}}};
            MODE_CHECKER: pix_d = checker_sel ? ~color_q : color_q;
            MODE_SCROLL:  pix_d = {scr_r, scr_g, scr_b};
            default:      pix_d = '0;
        endcase
    end

    logic [PIX_W-1:0] pix1_q;
    logic             vis1_q, hs1_q, vs1_q, fs1_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pix1_q <= '0;
            vis1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            fs1_q  <= 1'b0;
        end else begin
            pix1_q <= pix_d;
            vis1_q <= visible;
            hs1_q  <= h_sync_act;
            vs1_q  <= v_sync_act;
            fs1_q  <= first_pxl;
        end
    end

    // ---------------- stage 2: output registers ----------------
    logic [CB-1:0] red_q, green_q, blue_q;
    logic          h_sync_q, v_sync_q, frame_start_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            h_sync_q      <= ~H_ACT;
            v_sync_q      <= ~V_ACT;
            frame_start_q <= 1'b0;
        end else begin
            red_q         <= vis1_q ? pix1_q[PIX_W-1:2*CB] : '0;
            green_q       <= vis1_q ? pix1_q[2*CB-1:CB]    : '0;
            blue_q        <= vis1_q ? pix1_q[CB-1:0]       : '0;
            h_sync_q      <= hs1_q ? H_ACT : ~H_ACT;
            v_sync_q      <= vs1_q ? V_ACT : ~V_ACT;
            frame_start_q <= fs1_q;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Directed bench for vga_pattern_gen in a tiny 24x12 raster
//   (H 16/2/3/3, V 8/1/2/1). A second instance with inverted sync polarity
//   shares all inputs. Outputs are sampled on the falling clock edge.
module tb_vga_pattern_gen;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;  // 24
    localparam int VT = VV + VF + VS + VB;  // 12

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] color = 12'h000;

    always #5 clk = ~clk;

    logic [3:0] red, green, blue, red_n, green_n, blue_n;
    logic h_sync, v_sync, frame_start, h_sync_n, v_sync_n, frame_start_n;

    vga_pattern_gen #(
        .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HS),
        .H_BACK_PORCH_PXL(HB), .H_NUM_BITS(5),
        .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VS),
        .V_BACK_PORCH_PXL(VB), .V_NUM_BITS(4),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CHANNEL_BITS(4), .CHECKER_LOG2(2),
        .FRAME_BITS(8)
    ) dut (
        .clk(clk), .aresetn(aresetn), .mode(mode), .color(color),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
    );

    vga_pattern_gen #(
        .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HF), .H_SYNC_PULSE_PXL(HS),
        .H_BACK_PORCH_PXL(HB), .H_NUM_BITS(5),
        .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VF), .V_SYNC_PULSE_PXL(VS),
        .V_BACK_PORCH_PXL(VB), .V_NUM_BITS(4),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CHANNEL_BITS(4), .CHECKER_LOG2(2),
        .FRAME_BITS(8)
    ) dut_n (
        .clk(clk), .aresetn(aresetn), .mode(mode), .color(color),
        .red(red_n), .green(green_n), .blue(blue_n),
        .h_sync(h_sync_n), .v_sync(v_sync_n), .frame_start(frame_start_n)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int ph = 0, pv = 0, fr = 0;          // pixel currently on the pins, frame number
    logic [11:0] pix [0:VT-1][0:HT-1];   // last captured frame

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] exp_pix(input logic [1:0] m, input logic [11:0] c,
                                            input int h, input int v, input int f);
        int idx, r, g, b;
        logic [11:0] res;
        res = 12'h000;
        if (h < HV && v < VV) begin
            case (m)
                2'd0: res = c;
                2'd1: begin
                    idx = h / 2;
                    if (idx > 7) idx = 7;
                    case (idx)
                        0: res = 12'hFFF;
                        1: res = 12'hFF0;
                        2: res = 12'h0FF;
                        3: res = 12'h0F0;
                        4: res = 12'hF0F;
                        5: res = 12'hF00;
                        6: res = 12'h00F;
                        default: res = 12'h000;
                    endcase
                end
                2'd2: res = ((((h >> 2) ^ (v >> 2)) & 1) != 0) ? ~c : c;
                default: begin
                    r = ((h + f) >> 2) % 16;
                    g = (v >> 2) % 16;
                    b = f % 16;
                    res = {r[3:0], g[3:0], b[3:0]};
                end
            endcase
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        if (ph == HT - 1) begin
            ph = 0;
            if (pv == VT - 1) begin
                pv = 0;
                fr = fr + 1;
            end else begin
                pv = pv + 1;
            end
        end else begin
            ph = ph + 1;
        end
    endtask

    // Walks one full frame starting with pixel (0,0) on the pins. Mid-frame
    // the inputs are switched to nm/nc, which must only show next frame.
    task automatic scan_frame(input logic [1:0] em, input logic [11:0] ec,
                              input logic [1:0] nm, input logic [11:0] nc,
                              input string tag);
        int bad, hs_c, vs_c, fs_c;
        logic [11:0] obs, exp;
        logic ehs, evs;
        bad = 0; hs_c = 0; vs_c = 0; fs_c = 0;
        for (int i = 0; i < HT * VT; i++) begin
            obs = {red, green, blue};
            exp = exp_pix(em, ec, ph, pv, fr);
            pix[pv][ph] = obs;
            ehs = (ph >= HV + HF) && (ph < HV + HF + HS);
            evs = (pv >= VV + VF) && (pv < VV + VF + VS);
            if (obs !== exp) bad++;
            if ({red_n, green_n, blue_n} !== exp) bad++;
            if (h_sync !== ehs || v_sync !== evs) bad++;
            if (h_sync_n !== ~ehs || v_sync_n !== ~evs) bad++;
            if (frame_start !== (ph == 0 && pv == 0)) bad++;
            if (frame_start_n !== frame_start) bad++;
            if (h_sync === 1'b1) hs_c++;
            if (v_sync === 1'b1) vs_c++;
            if (frame_start === 1'b1) fs_c++;
            if (i == (HT * VT) / 2) begin
                mode  = nm;
                color = nc;
            end
            tick();
        end
        check({tag, "_bad_px"},    bad,  0);
        check({tag, "_hs_cycles"}, hs_c, 3 * VT);
        check({tag, "_vs_cycles"}, vs_c, 2 * HT);
        check({tag, "_fs_pulses"}, fs_c, 1);
    endtask

    // Release reset on a falling edge; pixel (0,0) must appear two edges later.
    task automatic release_reset(input string tag);
        aresetn = 1'b1;
        @(negedge clk);
        check({tag, "_fs_lat1"}, frame_start, 0);
        check({tag, "_rgb_lat1"}, {red, green, blue}, 12'h000);
        @(negedge clk);
        check({tag, "_fs_lat2"}, frame_start, 1);
        ph = 0; pv = 0; fr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        aresetn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rgb",      {red, green, blue}, 12'h000);
        check("rst_hsync",    h_sync, 0);
        check("rst_vsync",    v_sync, 0);
        check("rst_fs",       frame_start, 0);
        check("rst_hsync_n",  h_sync_n, 1);
        check("rst_vsync_n",  v_sync_n, 1);

        release_reset("boot");

        // Frame 0 runs on the reset-time latch (solid black).
        scan_frame(2'd0, 12'h000, 2'd0, 12'hF80, "f0_reset_latch");
        check("f0_p00", pix[0][0], 12'h000);

        // Frame 1: solid F80; colour changes to 0F0 mid-frame.
        scan_frame(2'd0, 12'hF80, 2'd0, 12'h0F0, "f1_solid");
        check("f1_p00",        pix[0][0],  12'hF80);
        check("f1_p15_7_late", pix[7][15], 12'hF80);
        check("f1_hblank",     pix[7][16], 12'h000);
        check("f1_vblank",     pix[8][0],  12'h000);

        scan_frame(2'd0, 12'h0F0, 2'd1, 12'h0F0, "f2_solid");
        check("f2_p00", pix[0][0], 12'h0F0);

        scan_frame(2'd1, 12'h0F0, 2'd2, 12'h123, "f3_bars");
        check("bars_p0",   pix[0][0],  12'hFFF);
        check("bars_p1",   pix[0][1],  12'hFFF);
        check("bars_p2",   pix[0][2],  12'hFF0);
        check("bars_p3",   pix[0][3],  12'hFF0);
        check("bars_p4",   pix[0][4],  12'h0FF);
        check("bars_l5p6", pix[5][6],  12'h0F0);
        check("bars_l5p8", pix[5][8],  12'hF0F);
        check("bars_p10",  pix[0][10], 12'hF00);
        check("bars_p12",  pix[0][12], 12'h00F);
        check("bars_p14",  pix[0][14], 12'h000);
        check("bars_l7p0", pix[7][0],  12'hFFF);

        scan_frame(2'd2, 12'h123, 2'd3, 12'h123, "f4_checker");
        check("chk_p0_0", pix[0][0], 12'h123);
        check("chk_p4_0", pix[0][4], 12'hEDC);
        check("chk_p4_4", pix[4][4], 12'h123);
        check("chk_p0_4", pix[4][0], 12'hEDC);

        // Frames 5..24 in scroll mode.
        for (int k = 5; k < 25; k++) begin
            scan_frame(2'd3, 12'h123, 2'd3, 12'h123, "scroll");
            if (k == 16) check("scroll_f16_p00", pix[0][0], 12'h400);
            if (k == 17) begin
                check("scroll_f17_p00", pix[0][0], 12'h401);
                check("scroll_f17_p34", pix[4][3], 12'h511);
            end
        end

        // Frame 25: advance to pixel (5,2), then drop reset mid-line.
        repeat (2 * HT + 5) tick();
        check("f25_p5_2", {red, green, blue}, 12'h709);
        aresetn = 1'b0;
        #1;
        check("midrst_rgb",     {red, green, blue}, 12'h000);
        check("midrst_hsync",   h_sync, 0);
        check("midrst_vsync",   v_sync, 0);
        check("midrst_hsync_n", h_sync_n, 1);
        check("midrst_vsync_n", v_sync_n, 1);
        repeat (3) @(negedge clk);
        check("midrst_hold_rgb", {red, green, blue}, 12'h000);

        // After reset the latched mode/colour are back to solid black.
        release_reset("rerun");
        scan_frame(2'd0, 12'h000, 2'd3, 12'h123, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
